// File: rtl/uram_wide_unloader.sv
// Reads full-width URAM rows and serializes each one onto a narrow valid/ready stream,
// least-significant slice first. One memory read is issued per row.
module uram_wide_unloader #(
    parameter int ADDR_LEN   = 9,
    parameter int DATA_LEN   = 128,
    parameter int DOUT_LEN   = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [ADDR_LEN-1:0] start_addr_i,
    input  logic [ADDR_LEN:0]   num_rows_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                mem_rd_en_o,
    output logic [ADDR_LEN-1:0] mem_rd_addr_o,
    input  logic [DATA_LEN-1:0] mem_rd_data_i,
    output logic [DOUT_LEN-1:0] dout_o,
    output logic                dout_valid_o,
    input  logic                dout_ready_i
);

    localparam int XFERS_PER_ROW = DATA_LEN / DOUT_LEN;
    localparam int BEAT_W        = $clog2(XFERS_PER_ROW + 1);
    localparam int LAT_W         = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_LEN-1:0] ADDR_ONE   = 1;
    localparam logic [ADDR_LEN:0]   ROWS_ONE   = 1;
    localparam logic [BEAT_W-1:0]   BEAT_ONE   = 1;
    localparam logic [BEAT_W-1:0]   BEAT_FULL  = XFERS_PER_ROW[BEAT_W-1:0];
    localparam logic [LAT_W-1:0]    LAT_ONE    = 1;
    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(RD_LATENCY - 1);

    logic [2:0]          state_q,     state_d;
    logic [ADDR_LEN-1:0] row_addr_q,  row_addr_d;
    logic [ADDR_LEN:0]   rows_left_q, rows_left_d;
    logic [BEAT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [LAT_W-1:0]    lat_cnt_q,   lat_cnt_d;
    logic [DATA_LEN-1:0] shift_q,     shift_d;

    always_comb begin
        state_d     = state_q;
        row_addr_d  = row_addr_q;
        rows_left_d = rows_left_q;
        beat_cnt_d  = beat_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        shift_d     = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    row_addr_d  = start_addr_i;
                    rows_left_d = num_rows_i;
                    state_d     = (num_rows_i == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                lat_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // Capture on the edge that ends the RD_LATENCY-th wait cycle.
                if (lat_cnt_q == LAT_LAST) begin
                    shift_d    = mem_rd_data_i;
                    beat_cnt_d = BEAT_FULL;
                    state_d    = ST_SHIFT;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_ONE;
                end
            end
            ST_SHIFT: begin
                if (dout_ready_i) begin
                    shift_d    = shift_q >> DOUT_LEN;
                    beat_cnt_d = beat_cnt_q - BEAT_ONE;
                    if (beat_cnt_q == BEAT_ONE) begin
                        row_addr_d  = row_addr_q + ADDR_ONE;
                        rows_left_d = rows_left_q - ROWS_ONE;
                        state_d     = (rows_left_q == ROWS_ONE) ? ST_DONE : ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            row_addr_q  <= '0;
            rows_left_q <= '0;
            beat_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            row_addr_q  <= row_addr_d;
            rows_left_q <= rows_left_d;
            beat_cnt_q  <= beat_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            shift_q     <= shift_d;
        end
    end

    // Outputs decode straight from state, so they take their idle values during reset.
    assign busy_o        = (state_q == ST_READ) || (state_q == ST_WAIT) || (state_q == ST_SHIFT);
    assign done_o        = (state_q == ST_DONE);
    assign mem_rd_en_o   = (state_q == ST_READ);
    assign mem_rd_addr_o = row_addr_q;
    assign dout_valid_o  = (state_q == ST_SHIFT);
    assign dout_o        = shift_q[DOUT_LEN-1:0];

endmodule

// File: tb/tb_uram_wide_unloader.sv
// Scoreboard bench for uram_wide_unloader: a URAM model with configurable latency feeds the DUT,
// expected read addresses and beats are queued at start time and checked by a separate monitor.
module tb_uram_wide_unloader;

    localparam int ADDR_LEN   = 4;
    localparam int DATA_LEN   = 128;
    localparam int DOUT_LEN   = 8;
    localparam int RD_LATENCY = 3;
    localparam int ROWS       = 1 << ADDR_LEN;
    localparam int XFERS      = DATA_LEN / DOUT_LEN;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [ADDR_LEN-1:0] start_addr;
    logic [ADDR_LEN:0]   num_rows;
    logic                busy;
    logic                done;
    logic                mem_rd_en;
    logic [ADDR_LEN-1:0] mem_rd_addr;
    logic [DATA_LEN-1:0] mem_rd_data;
    logic [DOUT_LEN-1:0] dout;
    logic                dout_valid;
    logic                dout_ready;

    uram_wide_unloader #(
        .ADDR_LEN  (ADDR_LEN),
        .DATA_LEN  (DATA_LEN),
        .DOUT_LEN  (DOUT_LEN),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .start_addr_i (start_addr),
        .num_rows_i   (num_rows),
        .busy_o       (busy),
        .done_o       (done),
        .mem_rd_en_o  (mem_rd_en),
        .mem_rd_addr_o(mem_rd_addr),
        .mem_rd_data_i(mem_rd_data),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // URAM model: rows plus a RD_LATENCY-deep read pipeline; junk when not enabled.
    logic [DATA_LEN-1:0] mem  [ROWS];
    logic [DATA_LEN-1:0] pipe [RD_LATENCY];

    always @(posedge clk) begin
        if (mem_rd_en) pipe[0] <= mem[mem_rd_addr];
        else           pipe[0] <= {4{$urandom}};
        for (int k = 1; k < RD_LATENCY; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rd_data = pipe[RD_LATENCY-1];

    // Scoreboard queues and monitor-side bookkeeping
    logic [ADDR_LEN-1:0] addr_q [$];
    logic [DOUT_LEN-1:0] beat_q [$];
    int done_seen    = 0;
    int beats_seen   = 0;
    int exp_done_cyc = -1;
    int ready_mode   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
    initial begin
        int phase = 0;
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       dout_ready = (phase % 3 == 0);
                2:       dout_ready = $urandom_range(0, 1) == 1;
                default: dout_ready = 1'b1;
            endcase
            phase++;
        end
    end

    // Monitor
    initial begin
        bit                  prev_stall = 0;
        logic [DOUT_LEN-1:0] prev_dout  = '0;
        bit                  first_pend = 0;
        int                  rd_cyc     = 0;
        bit                  exp_rd_vld = 0;
        int                  exp_rd_cyc = 0;
        int                  beat_in_row = 0;
        logic [DOUT_LEN-1:0] eb;
        logic [ADDR_LEN-1:0] ea;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall  = 0;
                first_pend  = 0;
                exp_rd_vld  = 0;
                beat_in_row = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", dout_valid, 1);
                    check("hold_dout", dout, prev_dout);
                end
                if (mem_rd_en || dout_valid) check("busy_active", busy, 1);
                if (mem_rd_en) begin
                    if (addr_q.size() == 0) begin
                        check("extra_rd", 1, 0);
                    end else begin
                        ea = addr_q.pop_front();
                        check("rd_addr", mem_rd_addr, ea);
                    end
                    if (exp_rd_vld) check("row_gap_rd_cycle", cyc, exp_rd_cyc);
                    exp_rd_vld = 0;
                    first_pend = 1;
                    rd_cyc     = cyc;
                end
                if (dout_valid && first_pend) begin
                    check("first_beat_latency", cyc - rd_cyc, RD_LATENCY + 1);
                    first_pend = 0;
                end
                if (dout_valid && dout_ready) begin
                    if (beat_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        eb = beat_q.pop_front();
                        check("beat", dout, eb);
                        if (beat_q.size() == 0) exp_done_cyc = cyc + 1;
                    end
                    beats_seen++;
                    beat_in_row++;
                    if (beat_in_row == XFERS) begin
                        beat_in_row = 0;
                        exp_rd_vld  = (beat_q.size() != 0);
                        exp_rd_cyc  = cyc + 1;
                    end
                end
                if (done) begin
                    check("done_cycle", cyc, exp_done_cyc);
                    check("done_busy", busy, 0);
                    check("done_beats_left", beat_q.size(), 0);
                    check("done_rds_left", addr_q.size(), 0);
                    done_seen++;
                end
                prev_stall = dout_valid && !dout_ready;
                prev_dout  = dout;
            end
        end
    end

    task automatic fill_mem();
        for (int r = 0; r < ROWS; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // poke: 0 = plain pulse, 1 = hold start into the following cycle, 2 = extra start mid-transfer
    task automatic issue_start(input logic [ADDR_LEN-1:0] sa, input int n, input int poke);
        for (int i = 0; i < n; i++) begin
            int r;
            r = (int'(sa) + i) % ROWS;
            addr_q.push_back(r[ADDR_LEN-1:0]);
            for (int j = 0; j < XFERS; j++) beat_q.push_back(mem[r][j*DOUT_LEN +: DOUT_LEN]);
        end
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = sa;
        num_rows   = n[ADDR_LEN:0];
        if (n == 0) exp_done_cyc = cyc + 1;
        @(posedge clk);
        #1;
        if (poke == 1) begin
            @(posedge clk);
            #1;
        end
        start      = 1'b0;
        start_addr = ADDR_LEN'($urandom);
        num_rows   = '0;
        if (poke == 2 && n > 0) begin
            repeat (2) @(posedge clk);
            #1;
            start      = 1'b1;
            start_addr = ADDR_LEN'($urandom);
            num_rows   = 1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic finish_xfer(input int d0);
        int i = 0;
        while (done_seen == d0 && i < 4000) begin
            @(negedge clk);
            i++;
        end
        #1;
        check("done_reached", done_seen > d0, 1);
        repeat (4) @(negedge clk);
        #1;
        check("done_once", done_seen - d0, 1);
        check("beats_left", beat_q.size(), 0);
        check("rds_left", addr_q.size(), 0);
        beat_q.delete();
        addr_q.delete();
    endtask

    task automatic run_xfer(input logic [ADDR_LEN-1:0] sa, input int n, input int mode, input int poke);
        int d0;
        d0         = done_seen;
        ready_mode = mode;
        issue_start(sa, n, poke);
        finish_xfer(d0);
        $display("[TB] xfer start=%0h rows=%0d ready_mode=%0d poke=%0d done, %0d checks so far",
                 sa, n, mode, poke, tests);
    endtask

    initial begin
        logic [127:0] ramp;
        int d0;
        int bs0;
        int i;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        num_rows   = '0;
        fill_mem();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        check("rst_dout", dout, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single row with a byte ramp, always ready
        ramp   = 128'h0F0E0D0C0B0A09080706050403020100;
        mem[0] = ramp;
        run_xfer(4'h0, 1, 0, 0);

        // Same row under 1,0,0 backpressure
        run_xfer(4'h0, 1, 1, 0);

        // Address wrap E, F, 0
        fill_mem();
        run_xfer(4'hE, 3, 1, 0);

        // Zero rows, start held into the DONE cycle
        run_xfer(4'h5, 0, 0, 1);

        // Full-bank unload wraps back to start
        fill_mem();
        run_xfer(4'h9, ROWS, 2, 0);

        // Reset mid-SHIFT after six beats
        fill_mem();
        ready_mode = 0;
        d0  = done_seen;
        bs0 = beats_seen;
        issue_start(4'h2, 3, 0);
        i = 0;
        while (beats_seen < bs0 + 6 && i < 200) begin
            @(negedge clk);
            i++;
        end
        #1;
        check("reset_reach_beat6", beats_seen - bs0, 6);
        reset = 1'b1;
        beat_q.delete();
        addr_q.delete();
        @(negedge clk);
        check("midrst_valid", dout_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_en", mem_rd_en, 0);
        check("midrst_dout", dout, 0);
        check("midrst_no_done", done_seen, d0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] reset mid-transfer applied after 6 beats");
        run_xfer(4'h2, 2, 0, 0);

        // Randomized transfers, some with a stray start while busy
        for (int t = 0; t < 6; t++) begin
            fill_mem();
            run_xfer(ADDR_LEN'($urandom), $urandom_range(0, 5), $urandom_range(0, 2),
                     $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
